// File: rtl/bcd_op_sequencer.sv
// bcd_op_sequencer
// Digit-serial 4-digit BCD arithmetic controller. On an accepted start it
// latches two BCD operands and an operator, then walks a single-digit BCD
// adder/subtractor over the digits (least significant first, one digit per
// cycle) to perform add, sign-magnitude subtract, or multiply by repeated
// shifted addition.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   start     operation request, sampled only while idle
//   clear     synchronous abort, same effect as reset, beats start
//   op        01 add, 10 subtract, 11 multiply, 00 invalid
//   bcd_a     operand A, 4 BCD digits, [15:12] most significant
//   bcd_b     operand B, same format
//   busy      high while an operation is being worked on
//   done      one-cycle pulse when result and flags are valid
//   result    BCD result magnitude, modulo 10000
//   negative  result is negative (subtract only)
//   overflow  true result is >= 10000
//   error     an operand digit was > 9 or op was 00
module bcd_op_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        clear,
  input  logic [1:0]  op,
  input  logic [15:0] bcd_a,
  input  logic [15:0] bcd_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        negative,
  output logic        overflow,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SUB1,
    S_SUB2,
    S_MUL_SEL,
    S_MUL_ADD,
    S_DONE
  } state_t;

  state_t      state_reg;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [15:0] acc_reg;
  logic [1:0]  k_reg;      // digit currently being processed
  logic [1:0]  i_reg;      // multiplier digit index
  logic [3:0]  count_reg;  // remaining additions for multiplier digit i
  logic        carry_reg;  // carry or borrow between digits
  logic        ovf_reg;    // sticky multiply overflow

  logic        busy_reg;
  logic        done_reg;
  logic [15:0] result_reg;
  logic        negative_reg;
  logic        overflow_reg;
  logic        error_reg;

  // Single-digit BCD add: returns {carry_out, digit}.
  function automatic logic [4:0] bcd_add(input logic [3:0] x, input logic [3:0] y,
                                         input logic c);
    logic [4:0] s;
    s = {1'b0, x} + {1'b0, y} + {4'd0, c};
    if (s > 5'd9)
      bcd_add = {1'b1, s[3:0] - 4'd10};
    else
      bcd_add = s;
  endfunction

  // Single-digit BCD subtract x - y - borrow: returns {borrow_out, digit}.
  // Operands are <= 9, so bit 4 of the 5-bit difference is the sign.
  function automatic logic [4:0] bcd_sub(input logic [3:0] x, input logic [3:0] y,
                                         input logic c);
    logic [4:0] d;
    d = {1'b0, x} - {1'b0, y} - {4'd0, c};
    if (d[4])
      bcd_sub = {1'b1, d[3:0] + 4'd10};
    else
      bcd_sub = {1'b0, d[3:0]};
  endfunction

  // Digit views of the latched operands and accumulator.
  logic [3:0] a_d   [4];
  logic [3:0] b_d   [4];
  logic [3:0] acc_d [4];
  logic [3:0] in_bad;     // per-digit invalid flags on the live inputs
  logic [3:0] lost_vec;   // nonzero A digits that fall off the top when shifted by i
  logic [15:0] acc_new;   // accumulator with digit k replaced by this cycle's digit

  logic [3:0] res_dig;
  logic       c_out;
  logic       cin;
  logic [1:0] sh_idx;
  logic [3:0] mul_dig;
  logic [3:0] b_sel;
  logic       lost;
  logic       start_bad;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign a_d[gi]   = a_reg[4*gi +: 4];
      assign b_d[gi]   = b_reg[4*gi +: 4];
      assign acc_d[gi] = acc_reg[4*gi +: 4];
      assign in_bad[gi] = (bcd_a[4*gi +: 4] > 4'd9) || (bcd_b[4*gi +: 4] > 4'd9);
      // Digit gi of A lands at position gi+i; beyond position 3 it is lost.
      assign lost_vec[gi] = (a_d[gi] != 4'd0) && (({1'b0, i_reg} + 3'(gi)) > 3'd3);
      assign acc_new[4*gi +: 4] = (k_reg == 2'(gi)) ? res_dig : acc_d[gi];
    end
  endgenerate

  assign start_bad = (|in_bad) || (op == 2'b00);
  assign lost      = |lost_vec;
  assign b_sel     = b_d[i_reg];
  assign sh_idx    = k_reg - i_reg;
  // A shifted left i digits: zeros enter below position i.
  assign mul_dig   = (k_reg >= i_reg) ? a_d[sh_idx] : 4'd0;
  // Every multi-digit pass starts with no carry/borrow in.
  assign cin       = (k_reg == 2'd0) ? 1'b0 : carry_reg;

  always_comb begin
    {c_out, res_dig} = 5'd0;
    case (state_reg)
      S_ADD:     {c_out, res_dig} = bcd_add(a_d[k_reg], b_d[k_reg], cin);
      S_SUB1:    {c_out, res_dig} = bcd_sub(a_d[k_reg], b_d[k_reg], cin);
      S_SUB2:    {c_out, res_dig} = bcd_sub(b_d[k_reg], a_d[k_reg], cin);
      S_MUL_ADD: {c_out, res_dig} = bcd_add(acc_d[k_reg], mul_dig, cin);
      default:   {c_out, res_dig} = 5'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_reg    <= S_IDLE;
      a_reg        <= 16'h0000;
      b_reg        <= 16'h0000;
      acc_reg      <= 16'h0000;
      k_reg        <= 2'd0;
      i_reg        <= 2'd0;
      count_reg    <= 4'd0;
      carry_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      result_reg   <= 16'h0000;
      negative_reg <= 1'b0;
      overflow_reg <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_reg        <= bcd_a;
            b_reg        <= bcd_b;
            acc_reg      <= 16'h0000;
            k_reg        <= 2'd0;
            i_reg        <= 2'd0;
            count_reg    <= 4'd0;
            carry_reg    <= 1'b0;
            ovf_reg      <= 1'b0;
            result_reg   <= 16'h0000;
            negative_reg <= 1'b0;
            overflow_reg <= 1'b0;
            error_reg    <= 1'b0;
            if (start_bad) begin
              // Rejected without any working cycle: straight to the done pulse.
              error_reg <= 1'b1;
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= S_DONE;
            end else begin
              busy_reg <= 1'b1;
              case (op)
                2'b01:   state_reg <= S_ADD;
                2'b10:   state_reg <= S_SUB1;
                default: state_reg <= S_MUL_SEL;
              endcase
            end
          end
        end

        S_ADD: begin
          acc_reg   <= acc_new;
          carry_reg <= c_out;
          k_reg     <= k_reg + 2'd1;
          if (k_reg == 2'd3) begin
            result_reg   <= acc_new;
            overflow_reg <= c_out;
            done_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= S_DONE;
          end
        end

        S_SUB1: begin
          acc_reg   <= acc_new;
          carry_reg <= c_out;
          k_reg     <= k_reg + 2'd1;
          if (k_reg == 2'd3) begin
            if (c_out) begin
              // A < B: redo as B - A and report the sign.
              state_reg <= S_SUB2;
            end else begin
              result_reg <= acc_new;
              done_reg   <= 1'b1;
              busy_reg   <= 1'b0;
              state_reg  <= S_DONE;
            end
          end
        end

        S_SUB2: begin
          acc_reg   <= acc_new;
          carry_reg <= c_out;
          k_reg     <= k_reg + 2'd1;
          if (k_reg == 2'd3) begin
            result_reg   <= acc_new;
            negative_reg <= 1'b1;
            done_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= S_DONE;
          end
        end

        S_MUL_SEL: begin
          if (b_sel == 4'd0) begin
            if (i_reg == 2'd3) begin
              result_reg   <= acc_reg;
              overflow_reg <= ovf_reg;
              done_reg     <= 1'b1;
              busy_reg     <= 1'b0;
              state_reg    <= S_DONE;
            end else begin
              i_reg <= i_reg + 2'd1;
            end
          end else begin
            count_reg <= b_sel;
            k_reg     <= 2'd0;
            carry_reg <= 1'b0;
            ovf_reg   <= ovf_reg | lost;
            state_reg <= S_MUL_ADD;
          end
        end

        S_MUL_ADD: begin
          acc_reg   <= acc_new;
          carry_reg <= c_out;
          k_reg     <= k_reg + 2'd1;
          if (k_reg == 2'd3) begin
            ovf_reg <= ovf_reg | c_out;
            if (count_reg == 4'd1) begin
              count_reg <= 4'd0;
              if (i_reg == 2'd3) begin
                // Last addition of the top digit: no further selection needed.
                result_reg   <= acc_new;
                overflow_reg <= ovf_reg | c_out;
                done_reg     <= 1'b1;
                busy_reg     <= 1'b0;
                state_reg    <= S_DONE;
              end else begin
                i_reg     <= i_reg + 2'd1;
                state_reg <= S_MUL_SEL;
              end
            end else begin
              count_reg <= count_reg - 4'd1;
            end
          end
        end

        S_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign result   = result_reg;
  assign negative = negative_reg;
  assign overflow = overflow_reg;
  assign error    = error_reg;

endmodule

// File: tb/tb_bcd_op_sequencer.sv
// Scoreboard bench for bcd_op_sequencer: stimulus pushes expected results
// with their expected done cycle; a monitor checks each done pulse.
module tb_bcd_op_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        clear;
  logic [1:0]  op;
  logic [15:0] bcd_a;
  logic [15:0] bcd_b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        negative;
  logic        overflow;
  logic        error;

  bcd_op_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .clear    (clear),
    .op       (op),
    .bcd_a    (bcd_a),
    .bcd_b    (bcd_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .negative (negative),
    .overflow (overflow),
    .error    (error)
  );

  typedef struct {
    string       name;
    logic [15:0] res;
    logic        neg;
    logic        ovf;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got result %0h with no pending operation (cycle %0d)",
                 result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ".result"},   32'(result),   32'(e.res));
        chk({e.name, ".negative"}, 32'(negative), 32'(e.neg));
        chk({e.name, ".overflow"}, 32'(overflow), 32'(e.ovf));
        chk({e.name, ".error"},    32'(error),    32'(e.err));
        chk({e.name, ".done_cyc"}, 32'(cyc),      32'(e.cyc));
        chk({e.name, ".busy_at_done"}, 32'(busy), 32'd0);
        $display("txn %s: result=%h neg=%0d ovf=%0d err=%0d at cycle %0d",
                 e.name, result, negative, overflow, error, cyc);
      end
    end
  end

  // Presents a start for one cycle (cycle 0 = the cycle start is high),
  // queues the expected response, then scrambles the operand inputs to show
  // they are not re-sampled. Returns at the negedge of cycle 1.
  task automatic issue(input string nm, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] o, input int lat, input logic [15:0] er,
                       input logic en, input logic eo, input logic ee);
    exp_t e;
    @(negedge clk);
    bcd_a = a;
    bcd_b = b;
    op    = o;
    start = 1'b1;
    e.name = nm; e.res = er; e.neg = en; e.ovf = eo; e.err = ee; e.cyc = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    bcd_a = 16'h9999;
    bcd_b = 16'h9999;
    op    = 2'b11;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clear = 1'b0;
    op    = 2'b00;
    bcd_a = 16'h0000;
    bcd_b = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset.busy",   32'(busy),     32'd0);
    chk("reset.done",   32'(done),     32'd0);
    chk("reset.result", 32'(result),   32'h0);
    chk("reset.flags",  32'({negative, overflow, error}), 32'd0);

    // Add with busy profile: high in cycles 1..4, low in cycle 5.
    issue("add_1234_5678", 16'h1234, 16'h5678, 2'b01, 5, 16'h6912, 1'b0, 1'b0, 1'b0);
    chk("add.busy_c1", 32'(busy), 32'd1);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk("add.busy_mid", 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk("add.busy_c5", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    // Add overflow, with a start held high through the DONE cycle.
    issue("add_ovf", 16'h9999, 16'h0001, 2'b01, 5, 16'h0000, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);           // now in cycle 5 (DONE)
    bcd_a = 16'h0001; bcd_b = 16'h0001; op = 2'b01; start = 1'b1;
    @(negedge clk);                      // cycle 6
    start = 1'b0;
    chk("start_in_done.busy_c6", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);

    issue("sub_borrow", 16'h0100, 16'h0250, 2'b10, 9, 16'h0150, 1'b1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    issue("sub_plain",  16'h0250, 16'h0100, 2'b10, 5, 16'h0150, 1'b0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    issue("sub_equal",  16'h1234, 16'h1234, 2'b10, 5, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);

    issue("mul_0012x3",   16'h0012, 16'h0003, 2'b11, 17, 16'h0036, 1'b0, 1'b0, 1'b0);
    repeat (18) @(negedge clk);
    issue("mul_5000x3",   16'h5000, 16'h0003, 2'b11, 17, 16'h5000, 1'b0, 1'b1, 1'b0);
    repeat (18) @(negedge clk);
    issue("mul_0123x20",  16'h0123, 16'h0020, 2'b11, 13, 16'h2460, 1'b0, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    issue("mul_shiftout", 16'h1234, 16'h1000, 2'b11, 9,  16'h4000, 1'b0, 1'b1, 1'b0);
    repeat (10) @(negedge clk);

    issue("err_digit", 16'h12A4, 16'h0001, 2'b01, 1, 16'h0000, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    issue("err_op00",  16'h0001, 16'h0001, 2'b00, 1, 16'h0000, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);

    // Abort a multiply with clear in cycle 10; drop its expectation since
    // no done pulse may appear for it.
    issue("mul_aborted", 16'h0999, 16'h0009, 2'b11, 41, 16'h8991, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_back());
    repeat (9) @(negedge clk);           // cycle 10
    clear = 1'b1;
    @(negedge clk);                      // cycle 11
    clear = 1'b0;
    chk("abort.busy",   32'(busy),   32'd0);
    chk("abort.done",   32'(done),   32'd0);
    chk("abort.result", 32'(result), 32'h0);
    chk("abort.flags",  32'({negative, overflow, error}), 32'd0);
    issue("add_after_abort", 16'h0001, 16'h0001, 2'b01, 5, 16'h0002, 1'b0, 1'b0, 1'b0);

    // Let any stray done pulse from the aborted multiply surface.
    repeat (50) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bcd_op_sequencer.md
# bcd_op_sequencer

Multi-cycle, digit-serial BCD arithmetic controller for the calculator datapath. It sits between operand/operator storage and the display path. It latches two 4-digit BCD operands and an operator code on a start pulse, then sequences a single-digit BCD adder/subtractor over the operands, one digit per cycle with least-significant digit first. When the operation finishes it returns a 4-digit BCD result, sign/overflow/error flags and a one-cycle done pulse. Add, subtract with sign-magnitude result, and multiply by digit-wise repeated addition are supported.

## Interface
Parameters: none (fixed at 4 BCD digits, 16 bits).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; all state and outputs to reset values on next edge
- start  in  1  request; sampled only in IDLE
- clear  in  1  synchronous abort (C key); same effect as reset, takes priority over start
- op  in  2  01 add, 10 subtract, 11 multiply; 00 invalid
- bcd_a  in  16  operand A, 4 BCD digits, [15:12] most significant
- bcd_b  in  16  operand B, same format
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when result is valid
- result  out  16  BCD result magnitude, modulo 10000
- negative  out  1  result is negative (subtract only)
- overflow  out  1  true result ≥ 10000
- error  out  1  invalid operand digit (>9) or op=00

## Operation
- States: IDLE, ADD, SUB1, SUB2, MUL_SEL, MUL_ADD, DONE.
- IDLE, start=1:
  - Latch bcd_a, bcd_b and op.
  - Clear the accumulator, flags and digit index.
  - Operand changes after the latch are ignored.
- Validation happens in the same cycle as the latch. If any digit of A or B is >9, or op=00, go directly to DONE with result=0 and error=1.
- ADD: 4 cycles, digit k (k=0..3) per cycle.
  - sum = a_k + b_k + carry; if sum>9, subtract 10 and set carry.
  - Final carry sets overflow.
  - Next state DONE.
- SUB1: 4 cycles computing A−B digit-wise with borrow (diff<0 → add 10, set borrow).
  - Final borrow 0 → DONE.
  - Final borrow 1 → SUB2, which recomputes B−A over 4 cycles and sets negative=1, then goes to DONE.
  - The SUB1 result is discarded on that path.
  - A=B gives 0000 with negative=0.
  - overflow is never set by subtract.
- MUL: accumulator starts at 0000; digit index i runs 0..3.
  - MUL_SEL (1 cycle): load count = b_i. If count=0, advance i; after i=3, go to DONE.
  - MUL_ADD (4 cycles per addition): accumulator += A shifted left i digits, with zeros shifted in. Then decrement count. Return to MUL_SEL when count=0 (i advances), otherwise repeat MUL_ADD.
  - overflow is sticky. It sets on any carry out of digit 3, or when a nonzero A digit is shifted out while b_i>0.
- DONE (1 cycle): done=1, busy=0, then go to IDLE unconditionally. start during DONE is ignored.
- result and the flags stay stable from DONE until the next accepted start, which clears them.
- start while busy is ignored; no queuing.

## Timing
- Reset values: busy=0, done=0, result=16'h0000, negative=0, overflow=0, error=0, state IDLE.
- Cycle 0 is the cycle in which start=1 is sampled in IDLE. busy=1 from cycle 1 through the last working cycle.
- Done pulse cycle:

  | op | Done in cycle |
  |---|---|
  | Add | 5 |
  | Subtract, no borrow | 5 |
  | Subtract, borrow | 9 |
  | Error | 1 |
  | Multiply | 4 + 4·(b0+b1+b2+b3) + 1; worst case 149 (B=9999) |

- reset or clear mid-operation: outputs return to reset values on the next edge and no done pulse is produced. clear and start asserted together → clear wins and start is dropped.
- result and the flags are registered outputs, updated only when DONE is entered or on start acceptance.

## Test plan
- **Add:** A=1234, B=5678, op=01, start in cycle 0 → done in cycle 5, result=6912, flags 0, busy high in cycles 1–4.
- **Add overflow, then start in DONE:**
  - A=9999, B=0001, op=01 → done in cycle 5, result=0000, overflow=1.
  - A second start held high during the DONE cycle is ignored: busy stays 0 in cycle 6.
- **Subtract with borrow:** A=0100, B=0250, op=10 → done in cycle 9, result=0150, negative=1. A=0250, B=0100 → done in cycle 5, result=0150, negative=0.
- **Multiply:**
  - A=0012, B=0003, op=11 → done in cycle 17, result=0036, overflow=0.
  - A=5000, B=0003 → done in cycle 17, result=5000, overflow=1.
- **Error:** A=12A4, op=01 → done in cycle 1, result=0000, error=1. op=00 with valid operands gives the same response.
- **Abort:**
  - A=0999, B=0009, op=11, clear in cycle 10 → all outputs at reset values from cycle 11, with no done pulse.
  - A new start in cycle 12 (A=0001, B=0001, op=01) → done in cycle 17, result=0002.
